vector_div_sequencer: RTL and testbench
=======================================

// Module: vector_div_sequencer
// PURPOSE
//  Top-level sequencer for the online-divider vector datapath. Drives the STATE / master_cnt /
//  fix_next_state / comp_cycle bus consumed by vector_delay_div and the digit RAM.
//  Runs one operation as WRITE_IN (fill RAM lines) -> READ_OUT -> READ_OUT_LAST_LINE -> END.
//  Sits between the host start/abort control and the divider datapath; one instance per divider.
// PARAMETERS
//  UNROLLING       4  digits per RAM line; fixed at 4 (master_cnt[1:0] is the digit index)
//  RAM_ADDR_WIDTH  7  RAM line address width; master_cnt is RAM_ADDR_WIDTH+2 bits
//  START/WRITE_IN/READ_OUT/READ_OUT_LAST_LINE/END  3'd0..3'd4  state encodings
// PORTS
//  clk             in   1       rising-edge clock
//  asyn_reset_n    in   1       asynchronous active-low reset
//  enable          in   1       clock-enable; low freezes all state, counters and outputs
//  start           in   1       begin an operation; sampled only in START with enable=1
//  abort           in   1       synchronous return to START from any state (enable=1)
//  comp_cycle_in   in   RAW     index of last RAM line (line count - 1)
//  STATE           out  3       current state encoding
//  master_cnt      out  RAW+2   read digit counter {line, digit}
//  comp_cycle      out  RAW     comp_cycle_in latched at start
//  fix_next_state  out  1       high in the first cycle of READ_OUT and of READ_OUT_LAST_LINE
//  ram_we          out  1       RAM write strobe, high throughout WRITE_IN
//  ram_addr        out  RAW     WRITE_IN: write line counter; read states: master_cnt[top:2]
//  busy            out  1       STATE != START
//  done            out  1       one-cycle pulse while in END
// BEHAVIOUR
//  - Reset: STATE=START; master_cnt, comp_cycle, ram_addr = 0; ram_we, fix_next_state, busy, done = 0.
//  - All outputs are registered or decoded from registers; no input-to-output combinational path.
//  - START: idle. If start=1, latch comp_cycle; wr_line=0; go to WRITE_IN next cycle.
//  - WRITE_IN: ram_we=1, ram_addr=wr_line, wr_line++ per cycle; after the cycle with
//    wr_line==comp_cycle: master_cnt<=0, next=READ_OUT (comp_cycle>0) or READ_OUT_LAST_LINE (comp_cycle==0).
//    Duration is exactly comp_cycle+1 cycles.
//  - READ_OUT: master_cnt++ per cycle; after the cycle with master_cnt=={comp_cycle-1,2'b11}, go to READ_OUT_LAST_LINE.
//  - READ_OUT_LAST_LINE: master_cnt++; after the cycle with master_cnt=={comp_cycle,2'b11}, go to END.
//    Total read cycles = 4*(comp_cycle+1); master_cnt never wraps.
//  - END: done=1 for one cycle; master_cnt held; next=START. A start in END is ignored.
//  - fix_next_state = (STATE!=prev_STATE) && STATE in {READ_OUT, READ_OUT_LAST_LINE};
//    prev_STATE is a register updated only when enable=1.
//  - enable=0: no register changes; done and fix_next_state hold their values for the stall
//    (pulse width counts enabled cycles).
//  - abort beats every other transition: next=START, clears counters and ram_we. done is not pulsed.
//  - comp_cycle_in changes mid-operation have no effect until the next start.
//  - asyn_reset_n low mid-operation: immediate return to reset values; no done pulse.
// STRUCTURE
//  - Shared package/include vector_div_defs: state encodings START..END, UNROLLING, RAM_ADDR_WIDTH.
//    Reused by vector_delay_div.
//  - One sub-module, vector_div_cnt: loadable, enable-gated up-counter with a terminal-match flag,
//    instanced twice (wr_line, master_cnt).
//  - FSM with next-state and output decode in the parent.
// TESTING
//  1. Reset: hold asyn_reset_n=0 -> STATE=0, master_cnt=0, ram_we=0, done=0. Release, start=1,
//     comp_cycle_in=2 -> WRITE_IN 3 cycles, ram_addr 0,1,2.
//  2. comp_cycle=2, full run -> READ_OUT for master_cnt 0..7; fix_next_state at master_cnt=0;
//     LAST_LINE for 8..11 (fix at 8); END 1 cycle with done=1; then START.
//  3. comp_cycle=0 -> WRITE_IN 1 cycle -> READ_OUT_LAST_LINE 4 cycles, fix_next_state at
//     master_cnt=0 -> END. READ_OUT never entered.
//  4. enable=0 for 5 cycles at master_cnt=5 -> all outputs frozen; resumes at 6, total read cycles
//     still 12.
//  5. abort at master_cnt=3 -> START next cycle, busy=0, done never pulses. comp_cycle_in changed
//     mid-run -> no effect.
//  6. comp_cycle=127 (max) -> master_cnt reaches 511 with no wrap; done after 128+512 cycles from
//     leaving START.

Source files
------------

// File: rtl/vector_div_sequencer_pkg.sv
// Shared definitions for the online-divider vector datapath.
// Holds the sequencer state encodings and the datapath geometry. The
// sequencer and the divider datapath both import this package so they
// agree on the STATE bus encoding.
package vector_div_sequencer_pkg;

    // Digits per RAM line; master_cnt[1:0] is the digit index within a line.
    localparam int UNROLLING      = 4;
    localparam int RAM_ADDR_WIDTH = 7;
    localparam int MCNT_WIDTH     = RAM_ADDR_WIDTH + 2;

    typedef enum logic [2:0] {
        ST_START              = 3'd0,
        ST_WRITE_IN           = 3'd1,
        ST_READ_OUT           = 3'd2,
        ST_READ_OUT_LAST_LINE = 3'd3,
        ST_END                = 3'd4
    } state_e;

endpackage

// File: rtl/vector_div_sequencer_cnt.sv
// vector_div_cnt: loadable, enable-gated up-counter with a terminal-match flag.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   en          clock enable; low freezes the count
//   load        load load_val (wins over inc)
//   inc         count up by one
//   load_val    value loaded when load=1
//   term_val    value compared against the current count
//   cnt         current count (registered)
//   term        cnt == term_val (decoded from the register)
module vector_div_cnt
    import vector_div_sequencer_pkg::*;
#(
    parameter int W = RAM_ADDR_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         load,
    input  logic         inc,
    input  logic [W-1:0] load_val,
    input  logic [W-1:0] term_val,
    output logic [W-1:0] cnt,
    output logic         term
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (inc) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt  = cnt_q;
    assign term = (cnt_q == term_val);

endmodule

// File: rtl/vector_div_sequencer.sv
// vector_div_sequencer: sequences one divider operation through
// WRITE_IN (fill RAM lines) -> READ_OUT -> READ_OUT_LAST_LINE -> END.
// Ports:
//   clk, asyn_reset_n  clock, asynchronous active-low reset
//   enable             clock enable; low freezes every register
//   start              begins an operation (sampled only in START)
//   abort              synchronous return to START from any state
//   comp_cycle_in      index of the last RAM line
//   STATE              current state encoding (also the FSM debug view)
//   master_cnt         read digit counter {line, digit}
//   comp_cycle         comp_cycle_in captured at start
//   fix_next_state     first cycle of READ_OUT / READ_OUT_LAST_LINE
//   ram_we, ram_addr   RAM write strobe and line address
//   busy, done         not idle / END pulse
// Handshake: start is a level qualified by enable while STATE==START; there
// is no ready, the operation is accepted on that edge. done is high for the
// single enabled cycle spent in END; abort never produces done.
module vector_div_sequencer
    import vector_div_sequencer_pkg::*;
(
    input  logic                      clk,
    input  logic                      asyn_reset_n,
    input  logic                      enable,
    input  logic                      start,
    input  logic                      abort,
    input  logic [RAM_ADDR_WIDTH-1:0] comp_cycle_in,
    output logic [2:0]                STATE,
    output logic [MCNT_WIDTH-1:0]     master_cnt,
    output logic [RAM_ADDR_WIDTH-1:0] comp_cycle,
    output logic                      fix_next_state,
    output logic                      ram_we,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
    output logic                      busy,
    output logic                      done
);

    state_e                    state_q, state_d;
    state_e                    prev_q;
    logic [RAM_ADDR_WIDTH-1:0] comp_cycle_q, comp_cycle_d;
    logic [RAM_ADDR_WIDTH-1:0] cc_m1;

    logic [RAM_ADDR_WIDTH-1:0] wr_line;
    logic                      wr_term;
    logic                      wr_load, wr_inc;

    logic [MCNT_WIDTH-1:0]     mc;
    logic [MCNT_WIDTH-1:0]     mc_term_val;
    logic                      mc_term;
    logic                      mc_load, mc_inc;

    assign cc_m1 = comp_cycle_q - RAM_ADDR_WIDTH'(1);

    // Terminal digit of the current phase: last digit of line comp_cycle-1
    // in READ_OUT, last digit of line comp_cycle otherwise.
    assign mc_term_val = (state_q == ST_READ_OUT) ? {cc_m1, 2'b11} : {comp_cycle_q, 2'b11};

    assign wr_load = abort || ((state_q == ST_START) && start);
    assign wr_inc  = (state_q == ST_WRITE_IN);
    assign mc_load = abort || ((state_q == ST_WRITE_IN) && wr_term);
    // The final increment is suppressed so master_cnt holds its last digit
    // into END instead of wrapping at the maximum line count.
    assign mc_inc  = (state_q == ST_READ_OUT) ||
                     ((state_q == ST_READ_OUT_LAST_LINE) && !mc_term);

    vector_div_cnt #(.W(RAM_ADDR_WIDTH)) u_wr_cnt (
        .clk      (clk),
        .rst_n    (asyn_reset_n),
        .en       (enable),
        .load     (wr_load),
        .inc      (wr_inc),
        .load_val ('0),
        .term_val (comp_cycle_q),
        .cnt      (wr_line),
        .term     (wr_term)
    );

    vector_div_cnt #(.W(MCNT_WIDTH)) u_master_cnt (
        .clk      (clk),
        .rst_n    (asyn_reset_n),
        .en       (enable),
        .load     (mc_load),
        .inc      (mc_inc),
        .load_val ('0),
        .term_val (mc_term_val),
        .cnt      (mc),
        .term     (mc_term)
    );

    always_comb begin
        state_d      = state_q;
        comp_cycle_d = comp_cycle_q;
        if (abort) begin
            state_d = ST_START;
        end else begin
            case (state_q)
                ST_START: begin
                    if (start) begin
                        state_d      = ST_WRITE_IN;
                        comp_cycle_d = comp_cycle_in;
                    end
                end
                ST_WRITE_IN: begin
                    if (wr_term) begin
                        state_d = (comp_cycle_q == '0) ? ST_READ_OUT_LAST_LINE : ST_READ_OUT;
                    end
                end
                ST_READ_OUT: begin
                    if (mc_term) state_d = ST_READ_OUT_LAST_LINE;
                end
                ST_READ_OUT_LAST_LINE: begin
                    if (mc_term) state_d = ST_END;
                end
                ST_END:  state_d = ST_START;
                default: state_d = ST_START;
            endcase
        end
    end

    always_ff @(posedge clk or negedge asyn_reset_n) begin
        if (!asyn_reset_n) begin
            state_q      <= ST_START;
            prev_q       <= ST_START;
            comp_cycle_q <= '0;
        end else if (enable) begin
            state_q      <= state_d;
            prev_q       <= state_q;
            comp_cycle_q <= comp_cycle_d;
        end
    end

    // All outputs decode registers only; prev_q follows state_q one enabled
    // cycle behind, so fix_next_state marks the first cycle of a read phase
    // and holds through a stall.
    assign STATE          = state_q;
    assign master_cnt     = mc;
    assign comp_cycle     = comp_cycle_q;
    assign fix_next_state = (state_q != prev_q) &&
                            ((state_q == ST_READ_OUT) || (state_q == ST_READ_OUT_LAST_LINE));
    assign ram_we         = (state_q == ST_WRITE_IN);
    assign ram_addr       = (state_q == ST_WRITE_IN) ? wr_line : mc[MCNT_WIDTH-1:2];
    assign busy           = (state_q != ST_START);
    assign done           = (state_q == ST_END);

endmodule

// File: tb/tb_vector_div_sequencer.sv
module tb_vector_div_sequencer;

  logic       clk = 1'b0;
  logic       asyn_reset_n;
  logic       enable;
  logic       start;
  logic       abort;
  logic [6:0] comp_cycle_in;
  logic [2:0] STATE;
  logic [8:0] master_cnt;
  logic [6:0] comp_cycle;
  logic       fix_next_state;
  logic       ram_we;
  logic [6:0] ram_addr;
  logic       busy;
  logic       done;

  int n_checks = 0;
  int n_pass   = 0;

  // observed/expected output bundle
  typedef struct packed {
    logic [2:0] st;
    logic [8:0] mc;
    logic [6:0] addr;
    logic       we;
    logic       fix;
    logic       dn;
    logic       bsy;
  } obs_t;

  obs_t exp_q[$];
  logic [8:0] model_mc;  // master_cnt value held from the previous operation

  typedef struct {
    int cc;
    int exp_wr;
    int exp_ro;
    int exp_rd;
  } vec_t;

  vector_div_sequencer dut (
    .clk            (clk),
    .asyn_reset_n   (asyn_reset_n),
    .enable         (enable),
    .start          (start),
    .abort          (abort),
    .comp_cycle_in  (comp_cycle_in),
    .STATE          (STATE),
    .master_cnt     (master_cnt),
    .comp_cycle     (comp_cycle),
    .fix_next_state (fix_next_state),
    .ram_we         (ram_we),
    .ram_addr       (ram_addr),
    .busy           (busy),
    .done           (done)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic obs_t snap();
    obs_t o;
    o.st   = STATE;
    o.mc   = master_cnt;
    o.addr = ram_addr;
    o.we   = ram_we;
    o.fix  = fix_next_state;
    o.dn   = done;
    o.bsy  = busy;
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // ---------------- reference model ----------------
  // Expected per-enabled-cycle outputs of one operation, starting with the
  // first WRITE_IN cycle and ending with the idle cycle after END.
  task automatic build_model(input int cc);
    obs_t o;
    int   nrd;
    for (int i = 0; i <= cc; i++) begin
      o = '{st: 3'd1, mc: model_mc, addr: 7'(i), we: 1'b1, fix: 1'b0, dn: 1'b0, bsy: 1'b1};
      exp_q.push_back(o);
    end
    nrd = 4 * (cc + 1);
    for (int k = 0; k < nrd; k++) begin
      o.st   = (k < 4 * cc) ? 3'd2 : 3'd3;
      o.mc   = 9'(k);
      o.addr = 7'(k / 4);
      o.we   = 1'b0;
      o.fix  = (k == 0) || (k == 4 * cc);
      o.dn   = 1'b0;
      o.bsy  = 1'b1;
      exp_q.push_back(o);
    end
    o = '{st: 3'd4, mc: 9'(nrd - 1), addr: 7'(cc), we: 1'b0, fix: 1'b0, dn: 1'b1, bsy: 1'b1};
    exp_q.push_back(o);
    o = '{st: 3'd0, mc: 9'(nrd - 1), addr: 7'(cc), we: 1'b0, fix: 1'b0, dn: 1'b0, bsy: 1'b0};
    exp_q.push_back(o);
    model_mc = 9'(nrd - 1);
  endtask

  // ---------------- drivers ----------------
  task automatic drive_start(input int cc);
    comp_cycle_in = 7'(cc);
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Full operation compared cycle by cycle; random stalls must freeze outputs
  // and comp_cycle_in is scrambled mid-run.
  task automatic run_op(input int cc, input int stall_pct);
    obs_t e;
    build_model(cc);
    drive_start(cc);
    comp_cycle_in = 7'($urandom_range(0, 127));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk($sformatf("trace cc=%0d", cc), 32'(snap()), 32'(e));
      if ($urandom_range(0, 99) < stall_pct) begin
        enable = 1'b0;
        repeat ($urandom_range(1, 4)) begin
          step();
          chk($sformatf("stall cc=%0d", cc), 32'(snap()), 32'(e));
        end
        enable = 1'b1;
      end
      if (exp_q.size() > 0) step();
    end
    chk("comp_cycle latched", 32'(comp_cycle), 32'(cc));
  endtask

  // Count cycles per phase until the sequencer returns to idle.
  task automatic measure(input vec_t v);
    int n_wr, n_ro, n_rd, n_done, budget;
    n_wr = 0; n_ro = 0; n_rd = 0; n_done = 0; budget = 0;
    drive_start(v.cc);
    while (STATE != 3'd0 && budget < 2000) begin
      if (STATE == 3'd1) n_wr++;
      if (STATE == 3'd2) n_ro++;
      if (STATE == 3'd2 || STATE == 3'd3) n_rd++;
      if (done) n_done++;
      if (done) chk($sformatf("end mc cc=%0d", v.cc), 32'(master_cnt), 32'(4 * v.cc + 3));
      budget++;
      step();
    end
    chk($sformatf("finish cc=%0d", v.cc), 32'(budget < 2000), 32'd1);
    chk($sformatf("write cycles cc=%0d", v.cc), 32'(n_wr), 32'(v.exp_wr));
    chk($sformatf("read_out cycles cc=%0d", v.cc), 32'(n_ro), 32'(v.exp_ro));
    chk($sformatf("read cycles cc=%0d", v.cc), 32'(n_rd), 32'(v.exp_rd));
    chk($sformatf("done pulses cc=%0d", v.cc), 32'(n_done), 32'd1);
    model_mc = 9'(4 * v.cc + 3);
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t vecs[4];
    int   found;
    int   n_done;
    obs_t frz;

    vecs[0] = '{cc: 2,   exp_wr: 3,   exp_ro: 8,   exp_rd: 12};
    vecs[1] = '{cc: 0,   exp_wr: 1,   exp_ro: 0,   exp_rd: 4};
    vecs[2] = '{cc: 5,   exp_wr: 6,   exp_ro: 20,  exp_rd: 24};
    vecs[3] = '{cc: 127, exp_wr: 128, exp_ro: 508, exp_rd: 512};

    asyn_reset_n  = 1'b0;
    enable        = 1'b1;
    start         = 1'b0;
    abort         = 1'b0;
    comp_cycle_in = 7'd0;
    model_mc      = 9'd0;

    // reset state
    repeat (3) step();
    chk("reset state",      32'(snap()), 32'(obs_t'{st: 3'd0, mc: 9'd0, addr: 7'd0, we: 1'b0, fix: 1'b0, dn: 1'b0, bsy: 1'b0}));
    chk("reset comp_cycle", 32'(comp_cycle), 32'd0);
    asyn_reset_n = 1'b1;
    step();

    // directed full runs through the model
    run_op(2, 0);
    run_op(0, 0);

    // table of phase lengths, including the maximum line count
    foreach (vecs[i]) measure(vecs[i]);

    // enable low for 5 cycles at master_cnt=5 (comp_cycle=2)
    drive_start(2);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (STATE == 3'd2 && master_cnt == 9'd5) found = 1;
      else step();
    end
    chk("stall reach mc=5", 32'(found), 32'd1);
    frz = snap();
    enable = 1'b0;
    repeat (5) begin
      step();
      chk("stall frozen", 32'(snap()), 32'(frz));
    end
    enable = 1'b1;
    step();
    chk("stall resume mc", 32'(master_cnt), 32'd6);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (done) found = 1;
      else step();
    end
    chk("stall done reached", 32'(found), 32'd1);
    chk("stall end mc", 32'(master_cnt), 32'd11);
    // start during END is ignored
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start in END ignored", 32'(STATE), 32'd0);
    step();
    chk("idle after END", 32'(STATE), 32'd0);
    model_mc = 9'd11;

    // abort at master_cnt=3 with comp_cycle_in changed mid-run
    drive_start(2);
    comp_cycle_in = 7'd9;
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (STATE == 3'd2 && master_cnt == 9'd3) found = 1;
      else step();
    end
    chk("abort reach mc=3", 32'(found), 32'd1);
    chk("comp_cycle unchanged", 32'(comp_cycle), 32'd2);
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort state", 32'(snap()), 32'(obs_t'{st: 3'd0, mc: 9'd0, addr: 7'd0, we: 1'b0, fix: 1'b0, dn: 1'b0, bsy: 1'b0}));
    n_done = 0;
    repeat (20) begin
      step();
      if (done) n_done++;
    end
    chk("abort no done", 32'(n_done), 32'd0);
    model_mc = 9'd0;

    // asynchronous reset mid-operation
    drive_start(3);
    repeat (7) step();
    #2 asyn_reset_n = 1'b0;
    #1;
    chk("async reset", 32'(snap()), 32'(obs_t'{st: 3'd0, mc: 9'd0, addr: 7'd0, we: 1'b0, fix: 1'b0, dn: 1'b0, bsy: 1'b0}));
    step();
    asyn_reset_n = 1'b1;
    model_mc = 9'd0;
    step();

    // randomized runs with random stalls against the model
    repeat (6) run_op($urandom_range(0, 12), 15);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
